// File: rtl/esn7e_top.sv
`default_nettype none
// ============================================================================
// Module      : esn7e_top
// Description : 8-neuron ring echo state network with an LFSR input source
//               and an on-chip LMS-trained linear readout, Q16.16 signed.
// Revision    : 1.0 - initial release
// ============================================================================
module esn7e_top #(
    parameter int                        N         = 8,
    parameter int                        DW        = 32,
    parameter int                        FRAC      = 16,
    parameter logic signed [DW-1:0]      W_RES     = 32'h0000E666,
    parameter logic signed [DW-1:0]      V_IN      = 32'h00008000,
    parameter logic        [N-1:0]       SIGN_MASK = 8'hA5,
    parameter int                        MU_SHIFT  = 6,
    parameter int                        DELAY     = 1,
    parameter logic        [15:0]        LFSR_SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_N,
    output logic [DW-1:0]   est,
    output logic [N*DW-1:0] W_out
);

    localparam logic [1:0] c_UPDATE   = 2'd0;
    localparam logic [1:0] c_ESTIMATE = 2'd1;
    localparam logic [1:0] c_LEARN    = 2'd2;

    localparam int c_HIST = (DELAY == 0) ? 1 : DELAY;

    localparam logic signed [DW-1:0]   c_MAX     = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]   c_MIN     = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [2*DW-1:0] c_SAT_HI  = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW-1:0] c_SAT_LO  = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam int                     c_ONE_I   = 1 << FRAC;
    localparam logic signed [DW-1:0]   c_ONE     = c_ONE_I[DW-1:0];
    localparam logic signed [DW-1:0]   c_NEG_ONE = -c_ONE;
    localparam logic signed [DW-1:0]   c_V_NEG   = -V_IN;

    function automatic logic signed [DW-1:0] sat_wide(input logic signed [2*DW-1:0] v);
        if (v > c_SAT_HI) return c_MAX;
        if (v < c_SAT_LO) return c_MIN;
        return v[DW-1:0];
    endfunction

    // Full-width product, floor-shifted back to Q16.16 before saturation.
    function automatic logic signed [DW-1:0] mul(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
        return sat_wide(p >>> FRAC);
    endfunction

    function automatic logic signed [DW-1:0] add_sat(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        logic signed [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1]) return s[DW] ? c_MIN : c_MAX;
        return s[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] sub_sat(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        logic signed [DW:0] s;
        s = {a[DW-1], a} - {b[DW-1], b};
        if (s[DW] != s[DW-1]) return s[DW] ? c_MIN : c_MAX;
        return s[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] clip(input logic signed [DW-1:0] v);
        if (v > c_ONE)     return c_ONE;
        if (v < c_NEG_ONE) return c_NEG_ONE;
        return v;
    endfunction

    logic [1:0]              r_phase;
    logic [15:0]             r_lfsr;
    logic signed [DW-1:0]    r_x      [N];
    logic signed [DW-1:0]    r_w      [N];
    logic signed [DW-1:0]    r_u_hist [c_HIST];
    logic signed [DW-1:0]    r_d;
    logic signed [DW-1:0]    r_est;

    logic [15:0]             w_lfsr_next;
    logic signed [DW-1:0]    w_u_cur;
    logic signed [DW-1:0]    w_d;
    logic signed [DW-1:0]    w_drive_pos;
    logic signed [DW-1:0]    w_drive_neg;
    logic signed [DW-1:0]    w_x_next [N];
    logic signed [DW-1:0]    w_est_sum;
    logic signed [DW-1:0]    w_err;
    logic signed [DW-1:0]    w_step   [N];
    logic signed [DW-1:0]    w_w_next [N];

    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_u_cur     = {{(DW-16){r_lfsr[15]}}, r_lfsr};
    assign w_drive_pos = mul(V_IN, w_u_cur);
    assign w_drive_neg = mul(c_V_NEG, w_u_cur);

    generate
        if (DELAY == 0) begin : g_d_direct
            assign w_d = w_u_cur;
        end else begin : g_d_delayed
            assign w_d = r_u_hist[DELAY-1];
        end
    endgenerate

    // Each neuron is fed only by its ring predecessor, all from the old state.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_x_next[i] = clip(add_sat(mul(W_RES, r_x[(i + N - 1) % N]),
                                       SIGN_MASK[i] ? w_drive_pos : w_drive_neg));
        end
    end

    always_comb begin
        w_est_sum = '0;
        for (int i = 0; i < N; i++) begin
            w_est_sum = add_sat(w_est_sum, mul(r_w[i], r_x[i]));
        end
    end

    assign w_err = sub_sat(r_d, r_est);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_step[i]   = mul(w_err, r_x[i]) >>> MU_SHIFT;
            w_w_next[i] = add_sat(r_w[i], w_step[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_N) begin
            r_phase <= c_UPDATE;
            r_lfsr  <= LFSR_SEED;
            r_d     <= '0;
            r_est   <= '0;
            for (int i = 0; i < N; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
            for (int k = 0; k < c_HIST; k++) begin
                r_u_hist[k] <= '0;
            end
        end else begin
            case (r_phase)
                c_UPDATE: begin
                    r_lfsr <= w_lfsr_next;
                    r_d    <= w_d;
                    for (int i = 0; i < N; i++) begin
                        r_x[i] <= w_x_next[i];
                    end
                    for (int k = c_HIST - 1; k > 0; k--) begin
                        r_u_hist[k] <= r_u_hist[k-1];
                    end
                    r_u_hist[0] <= w_u_cur;
                    r_phase     <= c_ESTIMATE;
                end
                c_ESTIMATE: begin
                    r_est   <= w_est_sum;
                    r_phase <= c_LEARN;
                end
                c_LEARN: begin
                    for (int i = 0; i < N; i++) begin
                        r_w[i] <= w_w_next[i];
                    end
                    r_phase <= c_UPDATE;
                end
                default: r_phase <= c_UPDATE;
            endcase
        end
    end

    assign est = r_est;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_wout
            assign W_out[DW*gi +: DW] = r_w[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_esn7e_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_esn7e_top
// Description : Self-checking bench for esn7e_top against a sample-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esn7e_top;

    localparam int N        = 8;
    localparam int DELAY    = 1;
    localparam int W_RES    = 32'h0000E666;
    localparam int V_IN     = 32'h00008000;
    localparam bit [7:0] SIGN_MASK = 8'hA5;
    localparam int MU_SHIFT = 6;
    localparam bit [15:0] SEED = 16'hACE1;

    logic         clk   = 1'b0;
    logic         rst_N = 1'b0;
    logic [31:0]  est;
    logic [255:0] W_out;

    esn7e_top dut (
        .clk   (clk),
        .rst_N (rst_N),
        .est   (est),
        .W_out (W_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, advanced one clock edge at a time.
    int        m_x [N];
    int        m_w [N];
    int        m_hist [4];
    int        m_d;
    int        m_est;
    bit [15:0] m_lfsr;
    int        m_step;
    bit        rec_en = 1'b0;
    longint    err_log [$];

    function automatic int sat(input longint v);
        longint hi, lo;
        hi = (longint'(1) << 31) - 1;
        lo = -(longint'(1) << 31);
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    function automatic int fx_mul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat(p >>> 16);
    endfunction

    function automatic int fx_add(input int a, input int b);
        return sat(longint'(a) + longint'(b));
    endfunction

    function automatic int fx_clip(input int v);
        if (v > 65536)  return 65536;
        if (v < -65536) return -65536;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0;
            m_w[i] = 0;
        end
        for (int k = 0; k < 4; k++) m_hist[k] = 0;
        m_d = 0; m_est = 0; m_lfsr = SEED; m_step = 0;
    endtask

    task automatic model_edge(input bit rn);
        int old [N];
        int u, e, s;
        if (!rn) begin
            model_reset();
            return;
        end
        if (m_step == 0) begin
            u = int'(shortint'(m_lfsr));
            old = m_x;
            for (int i = 0; i < N; i++)
                m_x[i] = fx_clip(fx_add(fx_mul(W_RES, old[(i + N - 1) % N]),
                                        fx_mul(SIGN_MASK[i] ? V_IN : -V_IN, u)));
            m_d = (DELAY == 0) ? u : m_hist[DELAY-1];
            for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = u;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_step = 1;
        end else if (m_step == 1) begin
            s = 0;
            for (int i = 0; i < N; i++) s = fx_add(s, fx_mul(m_w[i], m_x[i]));
            m_est  = s;
            m_step = 2;
        end else begin
            e = sat(longint'(m_d) - longint'(m_est));
            if (rec_en) err_log.push_back(longint'(e));
            for (int i = 0; i < N; i++) m_w[i] = fx_add(m_w[i], fx_mul(e, m_x[i]) >>> MU_SHIFT);
            m_step = 0;
        end
    endtask

    function automatic logic [255:0] pack_w(input int w [N]);
        logic [255:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = 32'(w[i]);
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit rn);
        rst_N = rn;
        @(posedge clk);
        model_edge(rn);
        #1;
        chk("model_est", {224'd0, est}, {224'd0, 32'(m_est)});
        chk("model_w", W_out, pack_w(m_w));
    endtask

    typedef struct {
        bit rst_n;
        int exp_est;
        int exp_w [N];
    } vec_t;

    vec_t tbl [8];

    task automatic run_table();
        for (int k = 0; k < 8; k++) begin
            cycle(tbl[k].rst_n);
            chk($sformatf("tbl%0d_est", k), {224'd0, est}, {224'd0, 32'(tbl[k].exp_est)});
            chk($sformatf("tbl%0d_w", k), W_out, pack_w(tbl[k].exp_w));
        end
    endtask

    initial begin
        real mse_first, mse_last;
        int  nsamp;

        // Two reset rows, then UPDATE/ESTIMATE/LEARN for two samples.
        for (int k = 0; k < 8; k++) begin
            tbl[k].rst_n   = (k >= 2);
            tbl[k].exp_est = 0;
            for (int i = 0; i < N; i++) tbl[k].exp_w[i] = 0;
        end
        tbl[7].exp_w = '{-10, 106, -107, 106, 9, -107, 106, -107};

        model_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0);
            chk("reset_est", {224'd0, est}, 256'd0);
            chk("reset_w", W_out, 256'd0);
        end

        rec_en = 1'b1;
        run_table();
        for (int c = 6; c < 30000; c++) cycle(1'b1);
        rec_en = 1'b0;

        nsamp = err_log.size();
        mse_first = 0.0;
        mse_last  = 0.0;
        for (int k = 0; k < 1000; k++) begin
            mse_first += real'(err_log[k]) * real'(err_log[k]);
            mse_last  += real'(err_log[nsamp-1000+k]) * real'(err_log[nsamp-1000+k]);
        end
        n_cmp++;
        if (!(mse_last < mse_first)) begin
            n_bad++;
            $display("FAIL mse_trend: last-window sum %f not below first-window sum %f", mse_last, mse_first);
        end

        // Align so the next edge would be an ESTIMATE, then reset on it.
        for (int c = 0; c < 3 && m_step != 1; c++) cycle(1'b1);
        cycle(1'b0);
        chk("midrst_est", {224'd0, est}, 256'd0);
        chk("midrst_w", W_out, 256'd0);
        run_table();

        for (int r = 0; r < 25; r++) begin
            int run_len, rst_len;
            run_len = $urandom_range(1, 60);
            rst_len = $urandom_range(1, 3);
            for (int c = 0; c < run_len; c++) cycle(1'b1);
            for (int c = 0; c < rst_len; c++) cycle(1'b0);
        end
        for (int c = 0; c < 90; c++) cycle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/esn7e_top.md
Name: esn7e_top

Overview:
- Self-contained echo state network (ESN) with online training.
- Holds an 8-neuron ring reservoir driven by an internal pseudo-random input.
- Produces a linear readout estimate and trains the readout weights on-chip with LMS, learning to reproduce the input delayed by DELAY samples.
- Top-level block with no data inputs; the estimate and all readout weights are exported for observation.

Parameters:
- N, 8, number of reservoir neurons.
- DW, 32, data width; signed Q16.16 fixed point throughout.
- FRAC, 16, fractional bits.
- W_RES, 32'h0000E666, ring feedback weight (≈0.9).
- V_IN, 32'h00008000, input weight magnitude (0.5).
- SIGN_MASK, 8'hA5, input sign per neuron: bit i=1 gives +V_IN, bit i=0 gives -V_IN.
- MU_SHIFT, 6, LMS step size = 2^-MU_SHIFT.
- DELAY, 1, target delay in samples; legal range 0..4.
- LFSR_SEED, 16'hACE1, input generator seed.

Ports:
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst_N, input, 1, synchronous active-low reset.
- est, output, 32, readout estimate, Q16.16 signed, registered.
- W_out, output, N*32 (256), readout weights; weight i at W_out[32*i +: 32], Q16.16 signed, registered.

Behaviour:
Reset:
- When rst_N=0 at a clock edge: phase <= UPDATE, lfsr <= LFSR_SEED, all x_i <= 0, u history <= 0, est <= 0, all weights <= 0.
- Reset asserted mid-sample aborts the sample; no partial state survives.

Arithmetic rules:
- mul(a,b) = 64-bit signed product arithmetically shifted right by FRAC (floor), then saturated to 32-bit signed.
- All additions are saturating to [-2^31, 2^31-1].
- clip(v) limits v to [-65536, +65536], i.e. ±1.0 activation.

Input u:
- u = sign-extend of lfsr[15:0] to 32 bits, giving a value in [-0.5, 0.5).
- lfsr is a Fibonacci LFSR: fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]; next = {lfsr[14:0], fb}.

FSM (3 cycles per sample, cycling UPDATE -> ESTIMATE -> LEARN -> UPDATE):
- UPDATE:
  - u_cur taken from the current lfsr value; lfsr then advances.
  - x_i <= clip(mul(W_RES, x_{(i-1) mod N}) + mul(±V_IN, u_cur)), all neurons updated in parallel from old x.
  - u history shifts in u_cur.
  - d = u_cur delayed DELAY samples (DELAY=0 means d = u_cur); d is latched for this sample.
- ESTIMATE: est <= saturating sum over i of mul(W_out_i, x_i).
- LEARN:
  - e = d - est (saturating).
  - W_out_i <= W_out_i + (mul(e, x_i) >>> MU_SHIFT), saturating, all i in parallel.
  - x and est are held.

Output timing and holds:
- est changes only in ESTIMATE; W_out changes only in LEARN.
- Outputs are stable for the other two cycles.
- Saturation never wraps; extreme values clamp and hold.

Test Plan:
- Reset: hold rst_N=0 for 10 cycles -> est=0, W_out=0 every cycle; after release the first edge performs UPDATE.
- First UPDATE, seed 0xACE1 (u0=-21279):
  - neurons with sign bit 1 (i=0,2,5,7) -> x_i=-10640; others -> x_i=10639.
  - lfsr becomes 0x59C3.
  - est remains 0 after ESTIMATE because weights are 0.
- First LEARN, DELAY=1: d=0, e=0 -> W_out stays all-zero.
- Second sample: d=-21279, est=0, so e=-21279 -> each W_out_i = (floor(-21279*x_i/65536)) >>> 6, checked against a bit-exact model.
- Long run of 30000 cycles: bench model of mean squared error over the last 1000 samples is below that of the first 1000; est/W_out match a bit-exact C/Python model every cycle.
- Mid-operation reset: assert rst_N=0 during an ESTIMATE cycle -> next edge gives all outputs 0, lfsr=LFSR_SEED; the sequence after release is identical to the one after power-on reset.
